key_conditioner: RTL and testbench

- Input-conditioning stage between the raw board pushbuttons and the paddle controllers.
- Per key, it provides:
  - two-flop synchronisation of the raw input;
  - a counter-based debouncer;
  - a hold/auto-repeat state machine.
- Outputs per key: a clean held level, one-cycle press/release strobes, and a move strobe. The move strobe fires on press, again after an initial delay, then at a fixed repeat period while the key is held.
- The paddle blocks use the outputs directly as up/down controls, so game logic sees no bounce and no metastability.

---
 rtl/key_conditioner_pkg.sv | 24 ++
 rtl/key_conditioner_channel.sv | 145 ++++++++++++++
 rtl/key_conditioner.sv | 38 +++
 tb/tb_key_conditioner.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/key_conditioner_pkg.sv
// rtl/key_conditioner_pkg.sv - shared types and sizing helpers for the key conditioner
package key_conditioner_pkg;

    // Per-key hold/auto-repeat state.
    typedef enum logic [1:0] {
        RELEASED    = 2'd0,
        HELD_DELAY  = 2'd1,
        HELD_REPEAT = 2'd2
    } key_state_t;

    // Bits needed for a counter that must be able to hold max_count.
    // Never returns less than 1 so a degenerate count still yields a legal vector.
    function automatic int cnt_width(input int max_count);
        int w;
        w = $clog2(max_count + 1);
        return (w < 1) ? 1 : w;
    endfunction

    // Larger of two cycle counts, used to size a timer shared by two phases.
    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_conditioner_channel.sv
// rtl/key_conditioner_channel.sv - one key: synchroniser, debouncer and hold/auto-repeat FSM
module key_channel
    import key_conditioner_pkg::*;
#(
    parameter int ACTIVE_LOW           = 1,
    parameter int DEBOUNCE_CYCLES      = 1000000,
    parameter int REPEAT_DELAY_CYCLES  = 15000000,
    parameter int REPEAT_PERIOD_CYCLES = 2500000
) (
    input  logic clk,
    input  logic reset,
    input  logic key_raw,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic key_move
);

    localparam int DB_W = cnt_width(DEBOUNCE_CYCLES);
    localparam int RP_W = cnt_width(max_of(REPEAT_DELAY_CYCLES, REPEAT_PERIOD_CYCLES));

    localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RP_W-1:0] DELAY_LAST = RP_W'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [RP_W-1:0] PERIOD_LAST = RP_W'(REPEAT_PERIOD_CYCLES - 1);

    // Raw level seen when the button is not pressed.
    localparam logic IDLE_RAW = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    logic sync1;
    logic sync2;
    logic pressed_q;

    logic            stable;
    logic [DB_W-1:0] db_cnt;
    logic            toggle;
    logic            rise;
    logic            fall;

    key_state_t      state;
    key_state_t      state_next;
    logic [RP_W-1:0] rp_cnt;
    logic [RP_W-1:0] rp_next;
    logic            move_next;

    // Two-flop synchroniser followed by a registered polarity normalisation (pressed = 1).
    // Reset reloads the idle level so a held key is seen as a fresh press afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1     <= IDLE_RAW;
            sync2     <= IDLE_RAW;
            pressed_q <= 1'b0;
        end else begin
            sync1     <= key_raw;
            sync2     <= sync1;
            pressed_q <= sync2 ^ IDLE_RAW;
        end
    end

    // A level change is accepted once the counter has seen DEBOUNCE_CYCLES differing samples.
    always_comb begin
        toggle = (pressed_q != stable) && (db_cnt == DB_LAST);
        rise   = toggle && !stable;
        fall   = toggle && stable;
    end

    // Debounce counter, accepted level and the registered press/release strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            stable      <= 1'b0;
            db_cnt      <= '0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
        end else begin
            if (pressed_q == stable) begin
                db_cnt <= '0;
            end else if (toggle) begin
                stable <= ~stable;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
            key_press   <= rise;
            key_release <= fall;
        end
    end

    // Repeat FSM next-state: a release always wins over a repeat strobe due in the same cycle.
    always_comb begin
        state_next = state;
        rp_next    = rp_cnt;
        move_next  = 1'b0;
        case (state)
            RELEASED: begin
                rp_next = '0;
                if (rise) begin
                    state_next = HELD_DELAY;
                    move_next  = 1'b1;
                end
            end
            HELD_DELAY: begin
                if (fall) begin
                    state_next = RELEASED;
                    rp_next    = '0;
                end else if (rp_cnt == DELAY_LAST) begin
                    state_next = HELD_REPEAT;
                    rp_next    = '0;
                    move_next  = 1'b1;
                end else begin
                    rp_next = rp_cnt + RP_W'(1);
                end
            end
            HELD_REPEAT: begin
                if (fall) begin
                    state_next = RELEASED;
                    rp_next    = '0;
                end else if (rp_cnt == PERIOD_LAST) begin
                    rp_next   = '0;
                    move_next = 1'b1;
                end else begin
                    rp_next = rp_cnt + RP_W'(1);
                end
            end
            default: begin
                state_next = RELEASED;
                rp_next    = '0;
            end
        endcase
    end

    // Repeat FSM state, timer and registered move strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= RELEASED;
            rp_cnt   <= '0;
            key_move <= 1'b0;
        end else begin
            state    <= state_next;
            rp_cnt   <= rp_next;
            key_move <= move_next;
        end
    end

    assign key_level = stable;

endmodule

// File: rtl/key_conditioner.sv
// rtl/key_conditioner.sv - top level: NUM_KEYS independent key conditioning channels
module key_conditioner
    import key_conditioner_pkg::*;
#(
    parameter int NUM_KEYS             = 4,
    parameter int ACTIVE_LOW           = 1,
    parameter int DEBOUNCE_CYCLES      = 1000000,
    parameter int REPEAT_DELAY_CYCLES  = 15000000,
    parameter int REPEAT_PERIOD_CYCLES = 2500000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] keys_raw,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_move
);

    // One self-contained channel per key; no arbitration between keys.
    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_channel #(
            .ACTIVE_LOW           (ACTIVE_LOW),
            .DEBOUNCE_CYCLES      (DEBOUNCE_CYCLES),
            .REPEAT_DELAY_CYCLES  (REPEAT_DELAY_CYCLES),
            .REPEAT_PERIOD_CYCLES (REPEAT_PERIOD_CYCLES)
        ) u_channel (
            .clk         (clk),
            .reset       (reset),
            .key_raw     (keys_raw[i]),
            .key_level   (key_level[i]),
            .key_press   (key_press[i]),
            .key_release (key_release[i]),
            .key_move    (key_move[i])
        );
    end

endmodule

// File: tb/tb_key_conditioner.sv
// tb/tb_key_conditioner.sv - directed self-checking bench for key_conditioner
module tb_key_conditioner;

    logic       clk;
    logic       reset;
    logic [3:0] keys_raw;
    logic [3:0] key_level;
    logic [3:0] key_press;
    logic [3:0] key_release;
    logic [3:0] key_move;

    int checks;
    int errors;

    logic [3:0] el;
    logic [3:0] ep;
    logic [3:0] er;
    logic [3:0] em;

    key_conditioner #(
        .NUM_KEYS             (4),
        .ACTIVE_LOW           (1),
        .DEBOUNCE_CYCLES      (4),
        .REPEAT_DELAY_CYCLES  (10),
        .REPEAT_PERIOD_CYCLES (3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .keys_raw    (keys_raw),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release),
        .key_move    (key_move)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [3:0] lv, input logic [3:0] pr,
                              input logic [3:0] rl, input logic [3:0] mv);
        check({tag, " level"},   {28'd0, key_level},   {28'd0, lv});
        check({tag, " press"},   {28'd0, key_press},   {28'd0, pr});
        check({tag, " release"}, {28'd0, key_release}, {28'd0, rl});
        check({tag, " move"},    {28'd0, key_move},    {28'd0, mv});
    endtask

    // Advance one rising edge and settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        reset    = 1'b1;
        keys_raw = 4'hF;

        // Reset state, then idle with nothing pressed.
        for (int e = 0; e < 3; e++) begin
            step();
            check_outs($sformatf("reset e%0d", e), 4'h0, 4'h0, 4'h0, 4'h0);
        end
        reset = 1'b0;
        for (int e = 0; e < 3; e++) begin
            step();
            check_outs($sformatf("idle e%0d", e), 4'h0, 4'h0, 4'h0, 4'h0);
        end

        // Key 0: clean press, auto-repeat, release on a repeat-due edge (28).
        for (int e = 0; e <= 35; e++) begin
            keys_raw = (e >= 22) ? 4'hF : 4'hE;
            step();
            el = {3'b0, (e >= 6 && e < 28)};
            ep = {3'b0, (e == 6)};
            er = {3'b0, (e == 28)};
            em = {3'b0, (e inside {6, 16, 19, 22, 25})};
            check_outs($sformatf("key0 e%0d", e), el, ep, er, em);
        end

        // Key 1: 3-cycle glitch must be rejected.
        for (int e = 0; e <= 12; e++) begin
            keys_raw = (e < 3) ? 4'hD : 4'hF;
            step();
            check_outs($sformatf("glitch e%0d", e), 4'h0, 4'h0, 4'h0, 4'h0);
        end

        // Key 1: bounce 0,1,0,0,0,... accepted only after the final stable run.
        for (int e = 0; e <= 12; e++) begin
            keys_raw = (e == 1) ? 4'hF : 4'hD;
            step();
            el = {2'b0, (e >= 8), 1'b0};
            ep = {2'b0, (e == 8), 1'b0};
            em = {2'b0, (e == 8), 1'b0};
            check_outs($sformatf("bounce e%0d", e), el, ep, 4'h0, em);
        end

        // Key 1 release; first delayed repeat still lands before the release.
        for (int e = 0; e <= 9; e++) begin
            keys_raw = 4'hF;
            step();
            el = {2'b0, (e < 6), 1'b0};
            er = {2'b0, (e == 6), 1'b0};
            em = {2'b0, (e == 5), 1'b0};
            check_outs($sformatf("rel1 e%0d", e), el, 4'h0, er, em);
        end

        // Keys 2 and 3 pressed together; key 2 released, key 3 keeps its cadence.
        for (int e = 0; e <= 30; e++) begin
            keys_raw = (e >= 17) ? 4'h7 : 4'h3;
            step();
            el = {(e >= 6), (e >= 6 && e < 23), 2'b0};
            ep = {(e == 6), (e == 6), 2'b0};
            er = {1'b0, (e == 23), 2'b0};
            em = {(e inside {6, 16, 19, 22, 25, 28}), (e inside {6, 16, 19, 22}), 2'b0};
            check_outs($sformatf("multi e%0d", e), el, ep, er, em);
        end

        // Key 3 release: the repeat due on the release edge is suppressed.
        for (int e = 0; e <= 9; e++) begin
            keys_raw = 4'hF;
            step();
            el = {(e < 6), 3'b0};
            er = {(e == 6), 3'b0};
            em = {(e inside {0, 3}), 3'b0};
            check_outs($sformatf("rel3 e%0d", e), el, 4'h0, er, em);
        end

        // Key 0 held into HELD_REPEAT, then reset mid-hold.
        for (int e = 0; e <= 20; e++) begin
            keys_raw = 4'hE;
            step();
            el = {3'b0, (e >= 6)};
            ep = {3'b0, (e == 6)};
            em = {3'b0, (e inside {6, 16, 19})};
            check_outs($sformatf("hold e%0d", e), el, ep, 4'h0, em);
        end
        reset = 1'b1;
        for (int e = 0; e < 2; e++) begin
            step();
            check_outs($sformatf("midrst e%0d", e), 4'h0, 4'h0, 4'h0, 4'h0);
        end
        reset = 1'b0;
        for (int e = 0; e <= 9; e++) begin
            step();
            el = {3'b0, (e >= 6)};
            ep = {3'b0, (e == 6)};
            em = {3'b0, (e == 6)};
            check_outs($sformatf("postrst e%0d", e), el, ep, 4'h0, em);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
